// File: rtl/equiv_checker.sv
// Compares behavioral and structural output buses vector by vector, counts
// mismatches, captures the first failing vector and reports a run verdict.
module equiv_checker #(
   parameter int NOUT  = 2,
   parameter int NVEC  = 20,
   parameter int IDX_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             vec_valid,
   input  logic [NOUT-1:0]  b_out,
   input  logic [NOUT-1:0]  s_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [IDX_W-1:0] vec_cnt,
   output logic [IDX_W-1:0] mismatch_cnt,
   output logic             fail_seen,
   output logic [IDX_W-1:0] first_fail_idx,
   output logic [NOUT-1:0]  first_fail_diff
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NVEC - 1);
   localparam logic [IDX_W-1:0] CNT_MAX  = '1;
   localparam logic [IDX_W-1:0] CNT_ONE  = IDX_W'(1);

   state_t            state_q, state_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic [IDX_W-1:0]  vec_cnt_q, vec_cnt_d;
   logic [IDX_W-1:0]  mismatch_cnt_q, mismatch_cnt_d;
   logic              fail_seen_q, fail_seen_d;
   logic [IDX_W-1:0]  first_fail_idx_q, first_fail_idx_d;
   logic [NOUT-1:0]   first_fail_diff_q, first_fail_diff_d;
   logic [NOUT-1:0]   diff;

   always_comb begin
      state_d           = state_q;
      vec_cnt_d         = vec_cnt_q;
      mismatch_cnt_d    = mismatch_cnt_q;
      fail_seen_d       = fail_seen_q;
      first_fail_idx_d  = first_fail_idx_q;
      first_fail_diff_d = first_fail_diff_q;
      diff              = b_out ^ s_out;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            // vec_valid is deliberately ignored here, even alongside start
            if (start) begin
               state_d           = ST_RUN;
               vec_cnt_d         = '0;
               mismatch_cnt_d    = '0;
               fail_seen_d       = 1'b0;
               first_fail_idx_d  = '0;
               first_fail_diff_d = '0;
            end
         end
         ST_RUN: begin
            if (vec_valid) begin
               vec_cnt_d = vec_cnt_q + CNT_ONE;
               if (|diff) begin
                  if (mismatch_cnt_q != CNT_MAX) begin
                     mismatch_cnt_d = mismatch_cnt_q + CNT_ONE;
                  end
                  if (!fail_seen_q) begin
                     fail_seen_d       = 1'b1;
                     first_fail_idx_d  = vec_cnt_q;
                     first_fail_diff_d = diff;
                  end
               end
               if (vec_cnt_q == LAST_IDX) begin
                  state_d = ST_DONE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Status flags follow the next state so they are valid with the counters
      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
      pass_d = done_d && (mismatch_cnt_d == '0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q           <= ST_IDLE;
         busy_q            <= 1'b0;
         done_q            <= 1'b0;
         pass_q            <= 1'b0;
         vec_cnt_q         <= '0;
         mismatch_cnt_q    <= '0;
         fail_seen_q       <= 1'b0;
         first_fail_idx_q  <= '0;
         first_fail_diff_q <= '0;
      end else begin
         state_q           <= state_d;
         busy_q            <= busy_d;
         done_q            <= done_d;
         pass_q            <= pass_d;
         vec_cnt_q         <= vec_cnt_d;
         mismatch_cnt_q    <= mismatch_cnt_d;
         fail_seen_q       <= fail_seen_d;
         first_fail_idx_q  <= first_fail_idx_d;
         first_fail_diff_q <= first_fail_diff_d;
      end
   end

   assign busy            = busy_q;
   assign done            = done_q;
   assign pass            = pass_q;
   assign vec_cnt         = vec_cnt_q;
   assign mismatch_cnt    = mismatch_cnt_q;
   assign fail_seen       = fail_seen_q;
   assign first_fail_idx  = first_fail_idx_q;
   assign first_fail_diff = first_fail_diff_q;

endmodule
